// File: rtl/sdram_ctrl_module_if.sv
// Host and stage-facing signal bundle for the SDRAM top-level sequencer.
// master is the sequencer side; slave is the host/stage side.
interface sdram_ctrl_module_if;
    logic       WrEN_Sig;
    logic       RdEN_Sig;
    logic       Done_Sig;
    logic       Busy_Sig;
    logic       Ready_Sig;
    logic       Init_Start_Sig;
    logic       Init_Done_Sig;
    logic [2:0] Func_Start_Sig;
    logic       Func_Done_Sig;

    modport master (
        input  WrEN_Sig,
        input  RdEN_Sig,
        input  Init_Done_Sig,
        input  Func_Done_Sig,
        output Done_Sig,
        output Busy_Sig,
        output Ready_Sig,
        output Init_Start_Sig,
        output Func_Start_Sig
    );

    modport slave (
        output WrEN_Sig,
        output RdEN_Sig,
        output Init_Done_Sig,
        output Func_Done_Sig,
        input  Done_Sig,
        input  Busy_Sig,
        input  Ready_Sig,
        input  Init_Start_Sig,
        input  Func_Start_Sig
    );
endinterface

// File: rtl/sdram_ctrl_module.sv
// SDRAM top-level sequencer: runs init, then arbitrates refresh,
// host writes and host reads into one-hot function-stage starts.
module sdram_ctrl_module #(
    parameter logic [9:0] T15US = 10'd300
) (
    input logic CLK,
    input logic RSTn,
    sdram_ctrl_module_if.master bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_REFRESH,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic       init_q, init_d;
    logic [2:0] func_q, func_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic [9:0] c1_q, c1_d;
    logic       pend_q, pend_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_INIT;
            init_q  <= 1'b0;
            func_q  <= 3'b000;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            c1_q    <= 10'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            func_q  <= func_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            c1_q    <= c1_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        func_d  = func_q;
        done_d  = done_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        c1_d    = c1_q;
        pend_d  = pend_q;

        unique case (state_q)
            S_INIT: begin
                init_d = 1'b1;
                if (bus.Init_Done_Sig) begin
                    init_d  = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (pend_q) begin
                    func_d  = 3'b100;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = S_REFRESH;
                end else if (bus.WrEN_Sig) begin
                    func_d  = 3'b001;
                    busy_d  = 1'b1;
                    state_d = S_WRITE;
                end else if (bus.RdEN_Sig) begin
                    func_d  = 3'b010;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_WRITE, S_READ, S_REFRESH: begin
                if (bus.Func_Done_Sig) begin
                    func_d  = 3'b000;
                    done_d  = (state_q != S_REFRESH);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        // an expiry on the same edge as refresh entry re-arms the flag
        if (ready_q) begin
            if (c1_q == T15US - 10'd1) begin
                c1_d   = 10'd0;
                pend_d = 1'b1;
            end else begin
                c1_d = c1_q + 10'd1;
            end
        end
    end

    assign bus.Init_Start_Sig = init_q;
    assign bus.Func_Start_Sig = func_q;
    assign bus.Done_Sig       = done_q;
    assign bus.Busy_Sig       = busy_q;
    assign bus.Ready_Sig      = ready_q;

endmodule

// File: tb/tb_sdram_ctrl_module.sv
// Self-checking bench for sdram_ctrl_module with a cycle-count refresh
// model, auto-responding init/function stages and randomized host traffic.
module tb_sdram_ctrl_module;
    localparam int T = 300;

    logic CLK = 1'b0;
    logic RSTn;

    sdram_ctrl_module_if bus();

    sdram_ctrl_module #(.T15US(10'd300)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    int edge_no    = 0;
    int ready_edge = -1;
    bit owed       = 1'b0;
    int done_cnt   = 0;
    int init_rises = 0;
    logic [2:0] prev_fs    = 3'b000;
    logic       prev_busy  = 1'b1;
    logic       prev_ready = 1'b0;
    logic       prev_init  = 1'b0;
    logic       wr_s, rd_s;
    logic [2:0] exp_code;
    logic [2:0] acc_q[$];
    int         ref_edges[$];

    int dur_wr   = 10;
    int dur_rd   = 10;
    int dur_ref  = 5;
    int init_dly = 20;
    int fcnt     = 0;
    int icnt     = 0;
    int dur_cur;

    // Reference model: refresh is owed every T edges after Ready rises,
    // and each IDLE acceptance follows refresh > write > read.
    always @(posedge CLK) begin
        wr_s = bus.WrEN_Sig;
        rd_s = bus.RdEN_Sig;
        edge_no++;
        #1;
        if (!RSTn) begin
            owed       = 1'b0;
            ready_edge = -1;
            prev_fs    = 3'b000;
            prev_busy  = 1'b1;
            prev_ready = 1'b0;
            prev_init  = 1'b0;
        end else begin
            if (prev_fs == 3'b000 && bus.Func_Start_Sig != 3'b000) begin
                exp_code = owed ? 3'b100 : wr_s ? 3'b001 : rd_s ? 3'b010 : 3'b000;
                n_checks++;
                if (bus.Func_Start_Sig !== exp_code) begin
                    n_fail++;
                    $display("FAIL accept_code edge %0d: got %b expected %b",
                             edge_no, bus.Func_Start_Sig, exp_code);
                end
                acc_q.push_back(bus.Func_Start_Sig);
                if (bus.Func_Start_Sig == 3'b100) ref_edges.push_back(edge_no);
                if (exp_code == 3'b100) owed = 1'b0;
            end else if (prev_fs == 3'b000 && !prev_busy && (owed || wr_s || rd_s)) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_accept edge %0d: got %b expected nonzero start",
                         edge_no, bus.Func_Start_Sig);
            end
            if (bus.Func_Start_Sig != 3'b000) begin
                n_checks++;
                if (!$onehot0(bus.Func_Start_Sig)) begin
                    n_fail++;
                    $display("FAIL onehot edge %0d: got %b expected one-hot",
                             edge_no, bus.Func_Start_Sig);
                end
            end
            if (bus.Done_Sig) done_cnt++;
            if (bus.Init_Start_Sig && !prev_init) init_rises++;
            if (bus.Ready_Sig && !prev_ready) ready_edge = edge_no;
            if (ready_edge >= 0 && edge_no > ready_edge && (edge_no - ready_edge) % T == 0)
                owed = 1'b1;
            prev_fs    = bus.Func_Start_Sig;
            prev_busy  = bus.Busy_Sig;
            prev_ready = bus.Ready_Sig;
            prev_init  = bus.Init_Start_Sig;
        end
    end

    // Init and function stage responders
    always @(posedge CLK) begin
        #1;
        if (!RSTn) begin
            fcnt              = 0;
            icnt              = 0;
            bus.Func_Done_Sig = 1'b0;
            bus.Init_Done_Sig = 1'b0;
        end else begin
            if (bus.Func_Start_Sig != 3'b000) begin
                fcnt++;
                dur_cur = (bus.Func_Start_Sig == 3'b001) ? dur_wr :
                          (bus.Func_Start_Sig == 3'b010) ? dur_rd : dur_ref;
                bus.Func_Done_Sig = (fcnt == dur_cur);
            end else begin
                fcnt              = 0;
                bus.Func_Done_Sig = 1'b0;
            end
            if (bus.Init_Start_Sig) begin
                icnt++;
                bus.Init_Done_Sig = (icnt == init_dly);
            end else begin
                icnt              = 0;
                bus.Init_Done_Sig = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks++;
        if (bus.Init_Start_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL %s init_start: got %b expected 0", tag, bus.Init_Start_Sig);
        end
        n_checks++;
        if (bus.Func_Start_Sig !== 3'b000) begin
            n_fail++;
            $display("FAIL %s func_start: got %b expected 000", tag, bus.Func_Start_Sig);
        end
        n_checks++;
        if (bus.Done_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: got %b expected 0", tag, bus.Done_Sig);
        end
        n_checks++;
        if (bus.Busy_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: got %b expected 1", tag, bus.Busy_Sig);
        end
        n_checks++;
        if (bus.Ready_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready: got %b expected 0", tag, bus.Ready_Sig);
        end
    endtask

    task automatic wait_done(input string tag, output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            if (bus.Done_Sig) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s timeout: got no Done_Sig expected pulse", tag);
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
    endtask

    task automatic test_init();
        int hi;
        int r0;
        r0 = init_rises;
        RSTn = 1'b1;
        tick();
        n_checks++;
        if (bus.Init_Start_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL init_rise: got %b expected 1", bus.Init_Start_Sig);
        end
        hi = 1;
        for (int i = 0; i < 200 && bus.Init_Start_Sig; i++) begin
            tick();
            if (bus.Init_Start_Sig) hi++;
        end
        n_checks++;
        if (hi != init_dly) begin
            n_fail++;
            $display("FAIL init_width: got %0d expected %0d", hi, init_dly);
        end
        n_checks++;
        if (bus.Ready_Sig !== 1'b1 || bus.Busy_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL init_ready: got ready=%b busy=%b expected ready=1 busy=0",
                     bus.Ready_Sig, bus.Busy_Sig);
        end
        repeat (30) tick();
        n_checks++;
        if (init_rises - r0 != 1) begin
            n_fail++;
            $display("FAIL init_once: got %0d expected 1", init_rises - r0);
        end
    endtask

    task automatic test_single_write();
        int hi = 0;
        int d0;
        bit got = 1'b0;
        d0 = done_cnt;
        dur_wr = 10;
        bus.WrEN_Sig = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (bus.Func_Start_Sig == 3'b001) hi++;
            if (bus.Done_Sig) begin
                got = 1'b1;
                bus.WrEN_Sig = 1'b0;
            end
        end
        n_checks++;
        if (!got || hi != 10) begin
            n_fail++;
            $display("FAIL wr_start_width: got %0d expected 10", hi);
        end
        n_checks++;
        if (bus.Func_Start_Sig !== 3'b000 || bus.Busy_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_done_cycle: got start=%b busy=%b expected 000/1",
                     bus.Func_Start_Sig, bus.Busy_Sig);
        end
        tick();
        n_checks++;
        if (bus.Done_Sig !== 1'b0 || bus.Busy_Sig !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_release: got done=%b busy=%b expected 0/0",
                     bus.Done_Sig, bus.Busy_Sig);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL wr_done_pulses: got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_wr_rd_simul();
        int got = 0;
        acc_q.delete();
        dur_wr = $urandom_range(2, 20);
        dur_rd = $urandom_range(2, 20);
        bus.WrEN_Sig = 1'b1;
        bus.RdEN_Sig = 1'b1;
        for (int i = 0; i < 500 && got < 2; i++) begin
            tick();
            if (bus.Done_Sig) begin
                got++;
                if (got == 1) bus.WrEN_Sig = 1'b0;
                else bus.RdEN_Sig = 1'b0;
            end
        end
        bus.WrEN_Sig = 1'b0;
        bus.RdEN_Sig = 1'b0;
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL simul_dones: got %0d expected 2", got);
        end
        n_checks++;
        if (acc_q.size() != 2) begin
            n_fail++;
            $display("FAIL simul_count: got %0d expected 2", acc_q.size());
        end else if (acc_q[0] !== 3'b001 || acc_q[1] !== 3'b010) begin
            n_fail++;
            $display("FAIL simul_order: got %b,%b expected 001,010", acc_q[0], acc_q[1]);
        end
        tick();
    endtask

    task automatic test_refresh_idle();
        int d0;
        d0 = done_cnt;
        ref_edges.delete();
        dur_ref = $urandom_range(3, 8);
        for (int i = 0; i < 1000 && edge_no < ready_edge + 700; i++) tick();
        n_checks++;
        if (ref_edges.size() != 2) begin
            n_fail++;
            $display("FAIL ref_idle_count: got %0d expected 2", ref_edges.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (ref_edges[k] < ready_edge + (k + 1) * T - 2 ||
                    ref_edges[k] > ready_edge + (k + 1) * T + 2) begin
                    n_fail++;
                    $display("FAIL ref_idle_time%0d: got %0d expected %0d+-2",
                             k, ref_edges[k] - ready_edge, (k + 1) * T);
                end
            end
        end
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL ref_idle_done: got %0d expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_refresh_long();
        bit got;
        int nref = 0;
        acc_q.delete();
        dur_rd = 650;
        dur_wr = 5;
        bus.RdEN_Sig = 1'b1;
        wait_done("long_read", got);
        bus.RdEN_Sig = 1'b0;
        bus.WrEN_Sig = 1'b1;
        wait_done("long_write", got);
        bus.WrEN_Sig = 1'b0;
        tick();
        foreach (acc_q[i]) if (acc_q[i] == 3'b100) nref++;
        n_checks++;
        if (nref != 1) begin
            n_fail++;
            $display("FAIL long_ref_count: got %0d expected 1", nref);
        end
        n_checks++;
        if (acc_q.size() != 3) begin
            n_fail++;
            $display("FAIL long_seq_len: got %0d expected 3", acc_q.size());
        end else if (acc_q[0] !== 3'b010 || acc_q[1] !== 3'b100 || acc_q[2] !== 3'b001) begin
            n_fail++;
            $display("FAIL long_seq: got %b,%b,%b expected 010,100,001",
                     acc_q[0], acc_q[1], acc_q[2]);
        end
    endtask

    task automatic test_random();
        logic [2:0] issued[$];
        logic [2:0] served[$];
        bit got;
        bit is_wr;
        acc_q.delete();
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 4)) tick();
            is_wr  = $urandom_range(0, 1);
            dur_wr = $urandom_range(1, 40);
            dur_rd = $urandom_range(1, 40);
            dur_ref = $urandom_range(1, 10);
            issued.push_back(is_wr ? 3'b001 : 3'b010);
            if (is_wr) bus.WrEN_Sig = 1'b1;
            else bus.RdEN_Sig = 1'b1;
            wait_done("rand_op", got);
            bus.WrEN_Sig = 1'b0;
            bus.RdEN_Sig = 1'b0;
        end
        tick();
        foreach (acc_q[i]) if (acc_q[i] != 3'b100) served.push_back(acc_q[i]);
        n_checks++;
        if (served.size() != issued.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d expected %0d", served.size(), issued.size());
        end else begin
            foreach (issued[i]) begin
                n_checks++;
                if (served[i] !== issued[i]) begin
                    n_fail++;
                    $display("FAIL rand_op%0d: got %b expected %b", i, served[i], issued[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int r0;
        bool_loop: begin end
        dur_wr = 100;
        bus.WrEN_Sig = 1'b1;
        for (int i = 0; i < 50 && bus.Func_Start_Sig != 3'b001; i++) tick();
        n_checks++;
        if (bus.Func_Start_Sig !== 3'b001) begin
            n_fail++;
            $display("FAIL midrst_start: got %b expected 001", bus.Func_Start_Sig);
        end
        repeat (3) tick();
        #3;
        RSTn = 1'b0;
        bus.WrEN_Sig = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) tick();
        r0 = init_rises;
        ref_edges.delete();
        RSTn = 1'b1;
        tick();
        n_checks++;
        if (bus.Init_Start_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_reinit: got %b expected 1", bus.Init_Start_Sig);
        end
        for (int i = 0; i < 100 && !bus.Ready_Sig; i++) tick();
        n_checks++;
        if (bus.Ready_Sig !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b expected 1", bus.Ready_Sig);
        end
        dur_ref = 4;
        for (int i = 0; i < 400 && edge_no < ready_edge + T + 10; i++) tick();
        n_checks++;
        if (ref_edges.size() != 1) begin
            n_fail++;
            $display("FAIL midrst_ref_count: got %0d expected 1", ref_edges.size());
        end else if (ref_edges[0] < ready_edge + T - 2 || ref_edges[0] > ready_edge + T + 2) begin
            n_fail++;
            $display("FAIL midrst_ref_time: got %0d expected %0d+-2",
                     ref_edges[0] - ready_edge, T);
        end
        n_checks++;
        if (init_rises - r0 != 1) begin
            n_fail++;
            $display("FAIL midrst_init_once: got %0d expected 1", init_rises - r0);
        end
    endtask

    initial begin
        RSTn              = 1'b0;
        bus.WrEN_Sig      = 1'b0;
        bus.RdEN_Sig      = 1'b0;
        bus.Init_Done_Sig = 1'b0;
        bus.Func_Done_Sig = 1'b0;
        test_reset();
        test_init();
        test_single_write();
        test_wr_rd_simul();
        test_refresh_idle();
        test_refresh_long();
        test_random();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_ctrl_module.md
# sdram_ctrl_module

Top-level sequencer for the SDRAM subsystem. It sits directly upstream of the SDRAM init stage and the SDRAM function (read/write/refresh) stage. After reset it starts the init stage and waits for it to finish. It then schedules periodic auto-refresh and arbitrates host write/read requests into one-hot start strobes for the function stage.

## Interface
Parameters:
- T15US, 10'd300: refresh interval in CLK cycles (15 us at 20 MHz).

Ports:
- CLK  in  1  system clock, 20 MHz.
- RSTn  in  1  reset; asynchronous, active-low.
- WrEN_Sig  in  1  host write request, level.
- RdEN_Sig  in  1  host read request, level.
- Done_Sig  out  1  one-cycle pulse when a host write/read completes.
- Busy_Sig  out  1  high whenever the controller cannot accept a host request.
- Ready_Sig  out  1  high once SDRAM init has completed.
- Init_Start_Sig  out  1  enable for the init stage; held until its done pulse.
- Init_Done_Sig  in  1  one-cycle done pulse from the init stage.
- Func_Start_Sig  out  3  one-hot start to the function stage: [2] refresh, [1] read, [0] write.
- Func_Done_Sig  in  1  one-cycle done pulse from the function stage.

## Operation
- Register-based; all outputs are driven from registers.
- Reset values: Init_Start_Sig=0, Func_Start_Sig=3'b000, Done_Sig=0, Busy_Sig=1, Ready_Sig=0. Refresh counter C1=0, refresh-pending flag=0, state=INIT.
- Asserting RSTn mid-operation aborts everything and forces the reset values. The full init sequence is re-run after release.

State machine:
- INIT
  - Drive Init_Start_Sig=1.
  - On an edge sampling Init_Done_Sig=1: Init_Start_Sig<=0, Ready_Sig<=1, go to IDLE.
  - Init_Start_Sig must drop on exactly that edge, so the init stage does not restart.
- IDLE (Busy_Sig=0)
  - Priority: pending refresh > WrEN_Sig > RdEN_Sig.
  - Refresh: Func_Start_Sig<=3'b100, Busy<=1, go to REFRESH, clear pending flag.
  - Write: Func_Start_Sig<=3'b001, Busy<=1, go to WRITE.
  - Read: Func_Start_Sig<=3'b010, Busy<=1, go to READ.
  - If WrEN and RdEN are both high, write wins; read is served on a later IDLE visit if still requested.
- WRITE / READ / REFRESH
  - Hold Func_Start_Sig until an edge samples Func_Done_Sig=1.
  - On that edge, Func_Start_Sig<=0.
  - WRITE/READ go to DONE with Done_Sig<=1.
  - REFRESH goes to DONE with Done_Sig held 0.
- DONE
  - Done_Sig<=0, Busy<=0, go to IDLE.

Refresh timer:
- C1 counts only while Ready_Sig=1, including during operations.
- When C1==T15US-1: C1<=0 and set the pending flag.
- A second expiry while the flag is still set leaves it set; only one refresh is queued.
- The flag is cleared only when REFRESH is entered.

Host rule: requests are sampled only in IDLE. The host holds its request until Done_Sig and deasserts it in the cycle Done_Sig is high. A request still high in the IDLE cycle after DONE is treated as a new request.

## Timing
- Init: Init_Start_Sig rises on the first CLK edge after RSTn release. Ready_Sig rises on the edge that samples Init_Done_Sig.
- Request latency: a request sampled in IDLE at edge k gives Func_Start_Sig high and Busy_Sig high after edge k.
- Completion: Func_Done_Sig sampled at edge m gives Func_Start_Sig=0 and Done_Sig=1 after edge m, then Done_Sig=0 and Busy_Sig=0 after edge m+1.
- The earliest next acceptance is edge m+2.
- Refresh: the pending flag sets T15US cycles after Ready_Sig rises, then every T15US cycles. Service is delayed at most one in-flight operation plus 2 cycles.
- Func_Start_Sig is never multi-hot and never nonzero outside WRITE/READ/REFRESH.

## Test plan
- Init handshake: release RSTn; respond to Init_Start_Sig with a one-cycle Init_Done_Sig after 20 cycles.
  - Init_Start_Sig=1 from cycle 1 and falls on the done edge.
  - Ready_Sig=1 and Busy_Sig=0 one cycle later.
  - No second Init_Start_Sig.
- Single write: hold WrEN_Sig in IDLE; Func_Done_Sig pulses 10 cycles after the start.
  - Func_Start_Sig=3'b001 for 10 cycles.
  - Done_Sig one-cycle pulse.
  - Busy_Sig low 2 cycles after Func_Done_Sig.
- Simultaneous WrEN_Sig and RdEN_Sig:
  - 3'b001 is served first, then 3'b010 after re-entering IDLE.
  - Two Done_Sig pulses.
- Refresh scheduling: idle 700 cycles after Ready_Sig.
  - Func_Start_Sig=3'b100 appears at 300 and 600 cycles (±2).
  - No Done_Sig pulses.
- Refresh vs. long operation: a read lasting 650 cycles spans two expiries.
  - Exactly one refresh is issued after the read's DONE, before any pending write.
- Reset mid-write: assert RSTn low during WRITE.
  - Outputs return to reset values immediately.
  - After release, the init sequence restarts and C1 restarts from 0.
